lsu_mem_port: RTL



---
 rtl/lsu_pkg.sv | 41 ++++
 rtl/lsu_align.sv | 43 ++++
 rtl/lsu_mem_port.sv | 127 ++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and request checks for the load/store unit.
package lsu_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        DATA  = 3'd2,
        WRITE = 3'd3,
        RESP  = 3'd4
    } lsu_state_t;

    // Request fields captured on the accept handshake.
    typedef struct packed {
        logic            we;
        logic [2:0]      funct3;
        logic [1:0]      lane;
        logic [XLEN-1:0] wdata;
    } lsu_req_t;

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] lo);
        case (funct3)
            F3_H, F3_HU: return lo[0];
            F3_W:        return lo != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

    function automatic logic is_illegal(input logic we, input logic [2:0] funct3);
        if (we) return funct3 > F3_W;
        return !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering: load extract/extend and sub-word store merge into the old RAM word.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [XLEN-1:0] wdata,
    input  logic [1:0]      lane,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] load_c,
    output logic [XLEN-1:0] merge_c
);

    function automatic logic [XLEN-1:0] load_extract(input logic [XLEN-1:0] word,
                                                     input logic [1:0] ln,
                                                     input logic [2:0] f3);
        logic [XLEN-1:0] sh;
        sh = word >> {ln, 3'b000};
        case (f3)
            F3_B:    return {{24{sh[7]}}, sh[7:0]};
            F3_BU:   return {24'd0, sh[7:0]};
            F3_H:    return {{16{sh[15]}}, sh[15:0]};
            F3_HU:   return {16'd0, sh[15:0]};
            default: return word;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] store_merge(input logic [XLEN-1:0] old,
                                                    input logic [XLEN-1:0] wd,
                                                    input logic [1:0] ln,
                                                    input logic [2:0] f3);
        logic [XLEN-1:0] mask;
        case (f3)
            F3_B:    mask = 32'h0000_00FF;
            F3_H:    mask = 32'h0000_FFFF;
            default: mask = 32'hFFFF_FFFF;
        endcase
        return (old & ~(mask << {ln, 3'b000})) | ((wd & mask) << {ln, 3'b000});
    endfunction

    assign load_c  = load_extract(rdata, lane, funct3);
    assign merge_c = store_merge(rdata, wdata, lane, funct3);

endmodule

// File: rtl/lsu_mem_port.sv
// RV32I load/store unit driving a word-wide, 1-cycle-read data RAM.
// Define LSU_PERF_EN to add load/store/error response counters.
module lsu_mem_port
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              mem_w_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef LSU_PERF_EN
    ,
    output logic [31:0]       perf_loads,
    output logic [31:0]       perf_stores,
    output logic [31:0]       perf_errs
`endif
);

    if (DATA_W != 32) begin : g_bad_width
        $error("lsu_mem_port: DATA_W must be 32");
    end

    lsu_state_t  state, state_next;
    lsu_req_t    req_q;
    logic        w_en_q;
    logic        accept_c;
    logic        bad_c;
    logic [XLEN-1:0] load_c, merge_c;

    assign accept_c = (state == IDLE) && req_valid;
    assign bad_c    = is_illegal(req_we, req_funct3) || is_misaligned(req_funct3, req_addr[1:0]);
    // Reset must suppress a write even when it lands on the WRITE cycle itself.
    assign mem_w_en = w_en_q & ~rst;

    lsu_align u_align (
        .rdata  (mem_rdata),
        .wdata  (req_q.wdata),
        .lane   (req_q.lane),
        .funct3 (req_q.funct3),
        .load_c (load_c),
        .merge_c(merge_c)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (bad_c)                             state_next = RESP;
                    else if (req_we && req_funct3 == F3_W) state_next = WRITE;
                    else                                   state_next = ADDR;
                end
            end
            ADDR:    state_next = DATA;
            DATA:    state_next = req_q.we ? WRITE : RESP;
            WRITE:   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Registered outputs follow the next state; datapath loads on accept and in DATA.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            w_en_q     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            req_q      <= '0;
        end else begin
            req_ready  <= state_next == IDLE;
            resp_valid <= state_next == RESP;
            w_en_q     <= state_next == WRITE;
            if (accept_c) begin
                req_q.we     <= req_we;
                req_q.funct3 <= req_funct3;
                req_q.lane   <= req_addr[1:0];
                req_q.wdata  <= req_wdata;
                mem_addr     <= {req_addr[ADDR_W-1:2], 2'b00};
                mem_wdata    <= req_wdata;
                resp_err     <= bad_c;
                resp_rdata   <= '0;
            end
            if (state == DATA) begin
                if (req_q.we) mem_wdata  <= merge_c;
                else          resp_rdata <= load_c;
            end
            if (state == RESP) resp_err <= 1'b0;
        end
    end

`ifdef LSU_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_loads  <= '0;
            perf_stores <= '0;
            perf_errs   <= '0;
        end else if (resp_valid) begin
            if (resp_err)      perf_errs   <= perf_errs + 32'd1;
            else if (req_q.we) perf_stores <= perf_stores + 32'd1;
            else               perf_loads  <= perf_loads + 32'd1;
        end
    end
`endif

endmodule
